joystick_adc_reader: RTL and testbench

- SPI master for an MCP3008-class 10-bit ADC.
- Alternately converts the joystick X and Y channels and presents both results as registered 10-bit values with a one-cycle update strobe.
- Sits upstream of the joystick-to-button converter, which consumes x_axis/y_axis directly.
- Free-running while enabled; results update as an atomic X/Y pair.

---
 rtl/joystick_adc_reader_pkg.sv | 28 ++
 rtl/joystick_adc_reader_if.sv | 10 +
 rtl/joystick_adc_reader_adc_spi_frame.sv | 118 +++++++++++
 rtl/joystick_adc_reader.sv | 80 ++++++++
 tb/tb_joystick_adc_reader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/joystick_adc_reader_pkg.sv
// Shared types and constants for the joystick ADC reader: frame FSM encoding,
// MCP3008 frame geometry and the MOSI command sequence.
package joystick_adc_pkg;

    typedef enum logic [1:0] {
        S_GAP   = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int FRAME_BITS     = 17;
    localparam int FIRST_DATA_BIT = 8;
    localparam int ADC_BITS       = 10;
    localparam logic [ADC_BITS-1:0] AXIS_CENTER = 10'd512;

    // DIN value for SCLK period n: start, single-ended, D2..D0, then zeros.
    function automatic logic cmd_bit(input logic [4:0] period, input logic [2:0] ch);
        case (period)
            5'd1, 5'd2: cmd_bit = 1'b1;
            5'd3:       cmd_bit = ch[2];
            5'd4:       cmd_bit = ch[1];
            5'd5:       cmd_bit = ch[0];
            default:    cmd_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/joystick_adc_reader_if.sv
// SPI bus between the joystick ADC reader (master) and the MCP3008 (slave).
interface joystick_adc_reader_if;
    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
    modport slave  (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/joystick_adc_reader_adc_spi_frame.sv
// One MCP3008 conversion frame: SCLK generation, command shift-out, MISO
// synchronizer and the 10-bit result shift register. All SPI outputs registered.
module adc_spi_frame
    import joystick_adc_pkg::*;
#(
    parameter int SCLK_DIV = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [2:0]          channel_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADC_BITS-1:0] data_o,
    joystick_adc_reader_if.master spi
);
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [4:0]          per_q, per_d;
    logic [2:0]          ch_q, ch_d;
    logic                sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic [ADC_BITS-1:0] sh_q, sh_d;
    logic                miso_s1_q, miso_s2_q;
    logic                div_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_GAP;
            div_q     <= '0;
            per_q     <= '0;
            ch_q      <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sh_q      <= '0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            per_q     <= per_d;
            ch_q      <= ch_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            sh_q      <= sh_d;
            miso_s1_q <= spi.spi_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        per_d    = per_q;
        ch_d     = ch_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        sh_d     = sh_q;
        div_last = (div_q == DIV_LAST);
        unique case (state_q)
            S_GAP: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (start_i) begin
                    state_d = S_SETUP;
                    ch_d    = channel_i;
                    div_d   = '0;
                    cs_n_d  = 1'b0;
                    mosi_d  = 1'b1;
                end
            end
            S_SETUP: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    per_d   = 5'd1;
                    sclk_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                div_d = div_q + 1'b1;
                // Two clk into the high phase the synchronizer shows the bit present at the rising edge.
                if (sclk_q && div_q == DIV_W'(1) && per_q >= 5'(FIRST_DATA_BIT))
                    sh_d = {sh_q[ADC_BITS-2:0], miso_s2_q};
                if (div_last) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        mosi_d = cmd_bit(per_q + 5'd1, ch_q);
                    end else if (per_q == 5'(FRAME_BITS)) begin
                        state_d = S_DONE;
                        cs_n_d  = 1'b1;
                    end else begin
                        sclk_d = 1'b1;
                        per_d  = per_q + 5'd1;
                    end
                end
            end
            S_DONE:  state_d = S_GAP;
            default: state_d = S_GAP;
        endcase
    end

    assign busy_o       = (state_q != S_GAP);
    assign done_o       = (state_q == S_DONE);
    assign data_o       = sh_q;
    assign spi.spi_cs_n = cs_n_q;
    assign spi.spi_sclk = sclk_q;
    assign spi.spi_mosi = mosi_q;

endmodule

// File: rtl/joystick_adc_reader.sv
// Free-running X/Y joystick reader: alternates ADC channels with an idle gap and
// publishes each X/Y pair atomically with a one-cycle sample_valid strobe.
module joystick_adc_reader
    import joystick_adc_pkg::*;
#(
    parameter int         SCLK_DIV   = 25,
    parameter logic [2:0] CH_X       = 3'd0,
    parameter logic [2:0] CH_Y       = 3'd1,
    parameter int         GAP_CYCLES = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    joystick_adc_reader_if.master spi,
    output logic [ADC_BITS-1:0]   x_axis,
    output logic [ADC_BITS-1:0]   y_axis,
    output logic                  sample_valid
);
    if (SCLK_DIV < 2) begin : g_bad_div
        $error("SCLK_DIV must be >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 1");
    end

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [GAP_W-1:0]    gap_q;
    logic                chan_q;  // 0: X frame next, 1: Y frame next
    logic [ADC_BITS-1:0] x_shadow_q, x_q, y_q;
    logic                valid_q;
    logic                busy, done, gap_done, start;
    logic [ADC_BITS-1:0] data;

    assign gap_done = (gap_q == GAP_LAST);
    // A Y frame always follows its X frame so a pair is never split by en.
    assign start    = !busy && gap_done && (en || chan_q);

    adc_spi_frame #(.SCLK_DIV(SCLK_DIV)) u_frame (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .channel_i (chan_q ? CH_Y : CH_X),
        .busy_o    (busy),
        .done_o    (done),
        .data_o    (data),
        .spi       (spi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q      <= '0;
            chan_q     <= 1'b0;
            x_shadow_q <= AXIS_CENTER;
            x_q        <= AXIS_CENTER;
            y_q        <= AXIS_CENTER;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= done && chan_q;
            if (done) begin
                gap_q  <= '0;
                chan_q <= !chan_q;
                if (chan_q) begin
                    x_q <= x_shadow_q;
                    y_q <= data;
                end else begin
                    x_shadow_q <= data;
                end
            end else if (!busy && !gap_done) begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

    assign x_axis       = x_q;
    assign y_axis       = y_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_joystick_adc_reader.sv
// Directed bench for joystick_adc_reader with an MCP3008 behavioural model.
module tb_joystick_adc_reader;
    localparam int DIV = 25;
    localparam int GAP = 200;
    localparam int FRAME_LOW = 35 * DIV;
    localparam logic [4:0] CMD_X = 5'b11000;
    localparam logic [4:0] CMD_Y = 5'b11001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [9:0] x_axis, y_axis;
    logic sample_valid;

    joystick_adc_reader_if spi ();

    joystick_adc_reader #(.SCLK_DIV(DIV), .CH_X(3'd0), .CH_Y(3'd1), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .spi          (spi),
        .x_axis       (x_axis),
        .y_axis       (y_axis),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ADC model and bus monitor, evaluated on the falling clk edge.
    logic [9:0] x_val = 10'h000, y_val = 10'h000, val;
    logic [4:0] cmd = 5'd0;
    logic       cs_p = 1'b1, sclk_p = 1'b0, v_p = 1'b0, seen = 1'b0;
    int         rises = 0, run = 0, cs_len = 0, hi_len = 0, nxt = 0;
    int         hi_bad = 0, lo_bad = 0, valid_cnt = 0, valid_long = 0;
    logic [9:0] last_x = 10'd0, last_y = 10'd0;
    logic [4:0] cmd_log[$];
    int         cslow_log[$];
    int         gap_log[$];

    initial spi.spi_miso = 1'b0;

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            valid_cnt++;
            last_x = x_axis;
            last_y = y_axis;
            if (v_p) valid_long++;
        end
        v_p = (sample_valid === 1'b1);
        if (spi.spi_cs_n === 1'b0) begin
            if (cs_p) begin
                if (seen) gap_log.push_back(hi_len);
                cs_len = 1; run = 1; rises = 0; cmd = 5'd0;
            end else begin
                cs_len++;
                if (spi.spi_sclk == sclk_p) run++;
                else begin
                    if (run != DIV) begin
                        if (sclk_p) hi_bad++; else lo_bad++;
                    end
                    run = 1;
                    if (spi.spi_sclk) begin
                        rises++;
                        if (rises <= 5) cmd = {cmd[3:0], spi.spi_mosi};
                    end else begin
                        nxt = rises + 1;
                        val = (cmd[2:0] == 3'd1) ? y_val : x_val;
                        spi.spi_miso = (nxt >= 8 && nxt <= 17) ? val[17-nxt] : 1'b0;
                    end
                end
            end
        end else begin
            if (!cs_p) begin
                cmd_log.push_back(cmd);
                cslow_log.push_back(cs_len);
                seen = 1'b1;
                if (run != DIV) lo_bad++;
                hi_len = 0;
            end
            hi_len++;
            spi.spi_miso = 1'b0;
        end
        cs_p   = (spi.spi_cs_n !== 1'b0);
        sclk_p = spi.spi_sclk;
    end

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0;
        repeat (3) tick();
        tests++; if (spi.spi_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b want 1", spi.spi_cs_n); end
        tests++; if (spi.spi_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", spi.spi_sclk); end
        tests++; if (spi.spi_mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", spi.spi_mosi); end
        tests++; if (x_axis !== 10'd512) begin fails++; $display("FAIL reset_x: got %0d want 512", x_axis); end
        tests++; if (y_axis !== 10'd512) begin fails++; $display("FAIL reset_y: got %0d want 512", y_axis); end
        tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    endtask

    task automatic test_first_pair;
        int n;
        x_val = 10'h3FF; y_val = 10'h000;
        rst = 1'b0; en = 1'b1;
        n = 0;
        while (cmd_log.size() < 1 && n < 3000) begin tick(); n++; end
        tests++; if (cmd_log.size() < 1) begin fails++; $display("FAIL first_x_frame: timeout, frames %0d want 1", cmd_log.size()); end
        tests++; if (cmd_log[0] !== CMD_X) begin fails++; $display("FAIL x_cmd_bits: got %b want %b", cmd_log[0], CMD_X); end
        tests++; if (cslow_log[0] != FRAME_LOW) begin fails++; $display("FAIL x_cs_low_len: got %0d want %0d", cslow_log[0], FRAME_LOW); end
        tests++; if (valid_cnt != 0) begin fails++; $display("FAIL no_strobe_after_x: got %0d pulses want 0", valid_cnt); end
        tests++; if (x_axis !== 10'd512) begin fails++; $display("FAIL x_held_after_x: got %0d want 512", x_axis); end
        n = 0;
        while (valid_cnt < 1 && n < 2000) begin tick(); n++; end
        tests++; if (valid_cnt != 1) begin fails++; $display("FAIL first_pair_strobe: got %0d pulses want 1", valid_cnt); end
        tests++; if (last_x !== 10'd1023) begin fails++; $display("FAIL first_pair_x: got %0d want 1023", last_x); end
        tests++; if (last_y !== 10'd0) begin fails++; $display("FAIL first_pair_y: got %0d want 0", last_y); end
        tests++; if (cmd_log[1] !== CMD_Y) begin fails++; $display("FAIL y_cmd_bits: got %b want %b", cmd_log[1], CMD_Y); end
        tests++; if (cslow_log[1] != FRAME_LOW) begin fails++; $display("FAIL y_cs_low_len: got %0d want %0d", cslow_log[1], FRAME_LOW); end
    endtask

    task automatic test_sweep;
        int n, v0, bad;
        logic [9:0] ex, ey;
        for (int p = 0; p < 10; p++) begin
            ex = p[0] ? 10'h155 : 10'h2AA;
            ey = p[0] ? 10'h2AA : 10'h155;
            x_val = ex; y_val = ey;
            v0 = valid_cnt; n = 0;
            while (valid_cnt == v0 && n < 2400) begin tick(); n++; end
            tests++; if (valid_cnt != v0 + 1) begin fails++; $display("FAIL sweep_strobe[%0d]: got %0d pulses want 1", p, valid_cnt - v0); end
            tests++; if (last_x !== ex || last_y !== ey) begin
                fails++; $display("FAIL sweep_pair[%0d]: got x=%h y=%h want x=%h y=%h", p, last_x, last_y, ex, ey);
            end
        end
        bad = 0;
        foreach (gap_log[i]) if (gap_log[i] != GAP + 1) bad++;
        tests++; if (bad != 0 || gap_log.size() < 21) begin fails++; $display("FAIL sweep_gap_len: %0d of %0d gaps not %0d", bad, gap_log.size(), GAP + 1); end
        bad = 0;
        foreach (cslow_log[i]) if (cslow_log[i] != FRAME_LOW) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL sweep_cs_low_len: %0d frames not %0d", bad, FRAME_LOW); end
        tests++; if (hi_bad != 0 || lo_bad != 0) begin fails++; $display("FAIL sclk_half_period: got %0d high / %0d low runs not %0d", hi_bad, lo_bad, DIV); end
        tests++; if (valid_long != 0) begin fails++; $display("FAIL strobe_width: got %0d long pulses want 0", valid_long); end
    endtask

    task automatic test_reset_mid_frame;
        int n, v0, sz0;
        n = 0;
        while (!(rises == 10 && cmd == CMD_Y && spi.spi_cs_n === 1'b0) && n < 3000) begin tick(); n++; end
        tests++; if (n >= 3000) begin fails++; $display("FAIL midrst_reach_y_p10: timeout after %0d cycles", n); end
        v0 = valid_cnt;
        rst = 1'b1;
        tick();
        tests++; if (spi.spi_cs_n !== 1'b1 || spi.spi_sclk !== 1'b0) begin
            fails++; $display("FAIL midrst_spi_idle: got cs_n=%b sclk=%b want 1 0", spi.spi_cs_n, spi.spi_sclk);
        end
        tests++; if (x_axis !== 10'd512 || y_axis !== 10'd512) begin
            fails++; $display("FAIL midrst_axes: got x=%0d y=%0d want 512 512", x_axis, y_axis);
        end
        tests++; if (sample_valid !== 1'b0 || valid_cnt != v0) begin
            fails++; $display("FAIL midrst_no_strobe: got valid=%b pulses=%0d want 0", sample_valid, valid_cnt - v0);
        end
        rst = 1'b0;
        tick();
        sz0 = cmd_log.size(); n = 0;
        while (cmd_log.size() == sz0 && n < GAP + 1200) begin tick(); n++; end
        tests++; if (cmd_log[$] !== CMD_X || cmd_log.size() == sz0) begin
            fails++; $display("FAIL midrst_next_is_x: got %b want %b", cmd_log[$], CMD_X);
        end
    endtask

    task automatic test_en_drop;
        int n, v0, sz0;
        v0 = valid_cnt; n = 0;
        while (valid_cnt == v0 && n < 3000) begin tick(); n++; end
        n = 0;
        while (spi.spi_cs_n !== 1'b0 && n < GAP + 50) begin tick(); n++; end
        tests++; if (spi.spi_cs_n !== 1'b0) begin fails++; $display("FAIL endrop_x_start: got cs_n=%b want 0", spi.spi_cs_n); end
        repeat (100) tick();
        en = 1'b0;
        v0 = valid_cnt; n = 0;
        while (valid_cnt == v0 && n < 2500) begin tick(); n++; end
        tests++; if (valid_cnt != v0 + 1) begin fails++; $display("FAIL endrop_pair_strobe: got %0d pulses want 1", valid_cnt - v0); end
        tests++; if (cmd_log[$] !== CMD_Y) begin fails++; $display("FAIL endrop_last_is_y: got %b want %b", cmd_log[$], CMD_Y); end
        tests++; if (last_x !== 10'h155 || last_y !== 10'h2AA) begin
            fails++; $display("FAIL endrop_pair: got x=%h y=%h want x=155 y=2aa", last_x, last_y);
        end
        sz0 = cmd_log.size();
        repeat (3000) tick();
        tests++; if (cmd_log.size() != sz0 || spi.spi_cs_n !== 1'b1) begin
            fails++; $display("FAIL endrop_stopped: got %0d extra frames cs_n=%b want 0 1", cmd_log.size() - sz0, spi.spi_cs_n);
        end
        en = 1'b1; n = 0;
        while (cmd_log.size() == sz0 && n < 2000) begin tick(); n++; end
        tests++; if (cmd_log.size() == sz0 || cmd_log[$] !== CMD_X) begin
            fails++; $display("FAIL enrise_next_is_x: got %b want %b", cmd_log[$], CMD_X);
        end
        tests++; if (gap_log[$] < GAP + 1) begin fails++; $display("FAIL enrise_gap: got %0d want >= %0d", gap_log[$], GAP + 1); end
    endtask

    task automatic test_hold_reset;
        int v0;
        rst = 1'b1; en = 1'b0;
        tick();
        v0 = valid_cnt;
        for (int c = 0; c < 100; c++) begin
            tick();
            tests++;
            if (spi.spi_cs_n !== 1'b1 || spi.spi_sclk !== 1'b0 || spi.spi_mosi !== 1'b0 ||
                x_axis !== 10'd512 || y_axis !== 10'd512 || sample_valid !== 1'b0) begin
                fails++;
                $display("FAIL hold_reset[%0d]: got cs_n=%b sclk=%b mosi=%b x=%0d y=%0d v=%b want 1 0 0 512 512 0",
                         c, spi.spi_cs_n, spi.spi_sclk, spi.spi_mosi, x_axis, y_axis, sample_valid);
            end
        end
        tests++; if (valid_cnt != v0) begin fails++; $display("FAIL hold_reset_strobe: got %0d pulses want 0", valid_cnt - v0); end
    endtask

    initial begin
        test_reset();
        test_first_pair();
        test_sweep();
        test_reset_mid_frame();
        test_en_drop();
        test_hold_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
